// File: rtl/sc_neuron_accumulator.sv
// rtl/sc_neuron_accumulator.sv - windowed accumulate-and-threshold stage for a stochastic-computing neuron
//
// Purpose:
//   Sits directly after the neuron's combinational adder. It integrates
//   NUMBER_INPUTS weighted synapse values into a running accumulator. On the
//   last value of each window it registers the window total and a spike
//   decision (total >= threshold), then holds them on a valid/ready output
//   until downstream consumes the result. This is the neuron's
//   integrate-and-fire step: one decision per window.
//
// Configuration macro:
//   SC_NACC_SATURATE_EN  defined   -> saturating add; overflow marks any saturation
//                        undefined -> wrap-around add; overflow marks a carry-out
//
// Ports:
//   SC_NACC_CLOCK_50          in   clock, rising edge
//   SC_NACC_RESET_InHigh      in   asynchronous reset, active-high
//   SC_NACC_clear_InHigh      in   synchronous clear; aborts the window and drops any result
//   SC_NACC_data_InBUS        in   weighted input value, unsigned
//   SC_NACC_valid_InHigh      in   input data valid
//   SC_NACC_ready_OutHigh     out  block can accept input (combinational)
//   SC_NACC_threshold_InBUS   in   firing threshold, sampled on the last accept of a window
//   SC_NACC_sum_OutBUS        out  registered window total
//   SC_NACC_spike_OutHigh     out  registered spike decision
//   SC_NACC_overflow_OutHigh  out  sticky overflow flag for the current window
//   SC_NACC_valid_OutHigh     out  sum/spike/overflow are valid
//   SC_NACC_ready_InHigh      in   downstream consumes the result

module sc_neuron_accumulator #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int NUMBER_INPUTS    = 4
) (
    input  logic                        SC_NACC_CLOCK_50,
    input  logic                        SC_NACC_RESET_InHigh,
    input  logic                        SC_NACC_clear_InHigh,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_NACC_data_InBUS,
    input  logic                        SC_NACC_valid_InHigh,
    output logic                        SC_NACC_ready_OutHigh,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_NACC_threshold_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_NACC_sum_OutBUS,
    output logic                        SC_NACC_spike_OutHigh,
    output logic                        SC_NACC_overflow_OutHigh,
    output logic                        SC_NACC_valid_OutHigh,
    input  logic                        SC_NACC_ready_InHigh
);

    localparam int W     = NUMBER_DATAWIDTH;
    localparam int CNT_W = (NUMBER_INPUTS > 1) ? $clog2(NUMBER_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_INPUTS - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             spike_q, spike_d;
    logic             valid_q, valid_d;

    logic             ready;
    logic             accept;
    logic [W:0]       add_full;
    logic             add_carry;
    logic [W-1:0]     add_res;

    assign ready  = (state_q == ST_ACC) && !SC_NACC_clear_InHigh;
    assign accept = SC_NACC_valid_InHigh && ready;

    // One extra bit captures the carry-out used for the overflow flag.
    always_comb begin
        add_full  = {1'b0, acc_q} + {1'b0, SC_NACC_data_InBUS};
        add_carry = add_full[W];
`ifdef SC_NACC_SATURATE_EN
        // Once the accumulator is all ones any further non-zero add carries
        // again, so the value stays pinned for the rest of the window.
        add_res   = add_carry ? {W{1'b1}} : add_full[W-1:0];
`else
        add_res   = add_full[W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sum_d      = sum_q;
        spike_d    = spike_q;
        valid_d    = valid_q;

        if (SC_NACC_clear_InHigh) begin
            // Clear outranks both the input accept and the output handshake.
            state_d    = ST_ACC;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            sum_d      = '0;
            spike_d    = 1'b0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d      = add_res;
                        overflow_d = overflow_q | add_carry;
                        if (count_q == LAST_CNT) begin
                            count_d = '0;
                            sum_d   = add_res;
                            spike_d = (add_res >= SC_NACC_threshold_InBUS);
                            valid_d = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // sum and spike stay as they are after consumption; only
                    // the window state restarts.
                    if (SC_NACC_ready_InHigh) begin
                        valid_d    = 1'b0;
                        acc_d      = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge SC_NACC_CLOCK_50 or posedge SC_NACC_RESET_InHigh) begin
        if (SC_NACC_RESET_InHigh) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sum_q      <= '0;
            spike_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sum_q      <= sum_d;
            spike_q    <= spike_d;
            valid_q    <= valid_d;
        end
    end

    assign SC_NACC_ready_OutHigh    = ready;
    assign SC_NACC_sum_OutBUS       = sum_q;
    assign SC_NACC_spike_OutHigh    = spike_q;
    assign SC_NACC_overflow_OutHigh = overflow_q;
    assign SC_NACC_valid_OutHigh    = valid_q;

endmodule

// File: tb/tb_sc_neuron_accumulator.sv
// tb/tb_sc_neuron_accumulator.sv - scoreboard bench for sc_neuron_accumulator
module tb_sc_neuron_accumulator;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         clear_in;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] thr_in;
    logic [W-1:0] sum_out;
    logic         spike_out;
    logic         ovf_out;
    logic         valid_out;
    logic         ready_in;

    sc_neuron_accumulator #(
        .NUMBER_DATAWIDTH(W),
        .NUMBER_INPUTS   (N)
    ) dut (
        .SC_NACC_CLOCK_50        (clk),
        .SC_NACC_RESET_InHigh    (rst),
        .SC_NACC_clear_InHigh    (clear_in),
        .SC_NACC_data_InBUS      (data_in),
        .SC_NACC_valid_InHigh    (valid_in),
        .SC_NACC_ready_OutHigh   (ready_out),
        .SC_NACC_threshold_InBUS (thr_in),
        .SC_NACC_sum_OutBUS      (sum_out),
        .SC_NACC_spike_OutHigh   (spike_out),
        .SC_NACC_overflow_OutHigh(ovf_out),
        .SC_NACC_valid_OutHigh   (valid_out),
        .SC_NACC_ready_InHigh    (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard entries: {overflow, spike, sum}
    logic [W+1:0] sb_q[$];

    // Reference model of the window in progress
    int m_acc = 0;
    int m_cnt = 0;
    int m_ovf = 0;

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic model_add(input int d);
        int s;
        s = m_acc + d;
        if (s > 255) begin
            m_ovf = 1;
`ifdef SC_NACC_SATURATE_EN
            s = 255;
`else
            s = s - 256;
`endif
        end
        m_acc = s;
        m_cnt++;
        if (m_cnt == N) begin
            sb_q.push_back({m_ovf[0], (m_acc >= int'(thr_in)), m_acc[W-1:0]});
            model_reset();
        end
    endtask

    // Drive one value and wait (bounded) until the DUT accepts it.
    task automatic send(input int d);
        int k;
        k = 0;
        valid_in = 1'b1;
        data_in  = W'(d);
        @(negedge clk);
        while (!ready_out && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready_out) begin
            check_eq("send_timeout", 0, 1);
            valid_in = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            model_add(d);
        end
    endtask

    // Monitor: each new result pops and checks one scoreboard entry.
    logic         vo_prev = 1'b0;
    logic [W+1:0] exp_e;
    always @(negedge clk) begin
        if (valid_out && !vo_prev) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                exp_e = sb_q.pop_front();
                check_eq("res_sum",   int'(sum_out),   int'(exp_e[W-1:0]));
                check_eq("res_spike", int'(spike_out), int'(exp_e[W]));
                check_eq("res_ovf",   int'(ovf_out),   int'(exp_e[W+1]));
            end
        end
        vo_prev = valid_out;
    end

    int bp_sum;
    int bp_spike;

    initial begin
        rst      = 1'b1;
        clear_in = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        thr_in   = 8'd100;
        ready_in = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_sum",   int'(sum_out),   0);
        check_eq("rst_spike", int'(spike_out), 0);
        check_eq("rst_ovf",   int'(ovf_out),   0);
        check_eq("rst_valid", int'(valid_out), 0);
        check_eq("rst_ready", int'(ready_out), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back window reaching exactly the threshold
        thr_in = 8'd100;
        send(10); send(20); send(30); send(40);
        check_eq("lat_valid", int'(valid_out), 1);
        check_eq("done_ready", int'(ready_out), 0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-window
        send(5); send(6);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_sum",   int'(sum_out),   0);
        check_eq("arst_spike", int'(spike_out), 0);
        check_eq("arst_valid", int'(valid_out), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("arst_ready", int'(ready_out), 1);
        @(posedge clk);
        #1;

        // Gapped inputs, one below threshold; also proves the window restarted at 0
        send(10); repeat (2) @(posedge clk); #1;
        send(20); repeat (2) @(posedge clk); #1;
        send(30); repeat (2) @(posedge clk); #1;
        send(39);
        repeat (2) @(posedge clk);
        #1;

        // Overflow window held under backpressure
        ready_in = 1'b0;
        send(200); send(100); send(0); send(0);
`ifdef SC_NACC_SATURATE_EN
        bp_sum = 255; bp_spike = 1;
`else
        bp_sum = 44;  bp_spike = 0;
`endif
        valid_in = 1'b1;
        data_in  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", int'(valid_out), 1);
            check_eq("bp_ready", int'(ready_out), 0);
            check_eq("bp_sum",   int'(sum_out),   bp_sum);
            check_eq("bp_spike", int'(spike_out), bp_spike);
            check_eq("bp_ovf",   int'(ovf_out),   1);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        send(7); send(7); send(7); send(7);
        repeat (2) @(posedge clk);
        #1;

        // Clear after two accepts, then a fresh window
        send(50); send(60);
        clear_in = 1'b1;
        #1;
        check_eq("clr_ready", int'(ready_out), 0);
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        model_reset();
        check_eq("clr_sum", int'(sum_out), 0);
        ready_in = 1'b0;
        send(1); send(2); send(3); send(4);
        @(negedge clk);
        #1;
        clear_in = 1'b1;
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        check_eq("clr_done_valid", int'(valid_out), 0);
        check_eq("clr_done_sum",   int'(sum_out),   0);
        check_eq("clr_done_spike", int'(spike_out), 0);
        ready_in = 1'b1;

        // Threshold 0 always spikes
        thr_in = 8'd0;
        send(0); send(0); send(0); send(0);
        repeat (3) @(posedge clk);
        #1;

        check_eq("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
